date_set_ctrl: RTL and testbench

- Parametrised date-entry controller for the clock/calendar front end; successor to the fixed four-digit date-set mode.
- While the mode selector equals `SET_MODE`, synchronised key pulses move a cursor across day, month and year fields and step the selected field.
- Unlike its predecessor, it clamps the day to the month length after every edit, loads the running date on entry, and emits a one-cycle commit pulse on exit.
- Optional auto-repeat steps the field while an up/down key is held.

---
 rtl/date_set_ctrl_if.sv | 21 ++
 rtl/date_set_ctrl.sv | 121 ++++++++++++
 tb/tb_date_set_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/date_set_ctrl_if.sv
// date_set_ctrl_if: key, load and date bundle between the UI front end and date_set_ctrl
interface date_set_ctrl_if #(parameter int YEAR_DIGITS = 4);
  logic [3:0]               NUM_SYNC;
  logic [1:0]               NUM_HOLD;
  logic                     TICK;
  logic [3:0]               MODE;
  logic                     LOAD;
  logic [4*YEAR_DIGITS-1:0] LD_YEAR;
  logic [3:0]               LD_MONTH;
  logic [4:0]               LD_DAY;
  logic [2:0]               CURSOR;
  logic [4*YEAR_DIGITS-1:0] YEAR;
  logic [3:0]               MONTH;
  logic [4:0]               DAY;
  logic                     DIRTY;
  logic                     COMMIT;
  modport master (output NUM_SYNC, NUM_HOLD, TICK, MODE, LOAD, LD_YEAR, LD_MONTH, LD_DAY,
                  input CURSOR, YEAR, MONTH, DAY, DIRTY, COMMIT);
  modport slave (input NUM_SYNC, NUM_HOLD, TICK, MODE, LOAD, LD_YEAR, LD_MONTH, LD_DAY,
                 output CURSOR, YEAR, MONTH, DAY, DIRTY, COMMIT);
endinterface

// File: rtl/date_set_ctrl.sv
// date_set_ctrl: day/month/BCD-year entry with month-length clamp and commit on exit; DATE_SET_AUTOREPEAT_EN adds held-key repeat
module date_set_ctrl #(
  parameter int          YEAR_DIGITS = 4,
  parameter logic [3:0]  SET_MODE    = 4'b0000,
  parameter logic [15:0] RST_YEAR    = 16'h2020,
  parameter int          RPT_DELAY   = 50,
  parameter int          RPT_RATE    = 10
) (
  input logic CLK,
  input logic RESET,
  date_set_ctrl_if.slave u
);
  localparam int YW = 4*YEAR_DIGITS;
  localparam logic [2:0] CMAX = 3'(YEAR_DIGITS+1);
  function automatic logic div4(input logic [3:0] t, input logic [3:0] o);
    return t[0] ? (o == 4'd2 || o == 4'd6) : (o == 4'd0 || o == 4'd4 || o == 4'd8);
  endfunction
  // centuries fall back to the divisibility of the hundreds part by four
  function automatic logic leap(input logic [YW-1:0] y);
    logic [15:0] p;
    p = 16'(y);
    return (YEAR_DIGITS >= 3 && p[7:0] == 8'h00) ? div4(p[15:12], p[11:8]) : div4(p[7:4], p[3:0]);
  endfunction
  function automatic logic [4:0] dim(input logic [3:0] m, input logic lp);
    return (m == 4'd2) ? (lp ? 5'd29 : 5'd28) :
           (m == 4'd4 || m == 4'd6 || m == 4'd9 || m == 4'd11) ? 5'd30 : 5'd31;
  endfunction
  logic          edit, edit_q, entry, leave, mv_r, mv_l, rpt_up, rpt_dn, st_up, st_dn, step;
  logic [2:0]    cur_q, cur_n;
  logic [YW-1:0] year_q, year_n;
  logic [3:0]    mon_q, mon_n;
  logic [4:0]    day_q, day_n, dcur;
  logic          dirty_q, dirty_n, commit_q, commit_n;
  assign edit  = u.MODE == SET_MODE;
  assign entry = edit && !edit_q;
  assign leave = !edit && edit_q;
  assign mv_r  = u.NUM_SYNC[2] && !u.NUM_SYNC[3];
  assign mv_l  = u.NUM_SYNC[3] && !u.NUM_SYNC[2];
  assign st_up = (u.NUM_SYNC[0] || rpt_up) && !(u.NUM_SYNC[1] || rpt_dn);
  assign st_dn = (u.NUM_SYNC[1] || rpt_dn) && !(u.NUM_SYNC[0] || rpt_up);
  assign step  = st_up || st_dn;
  assign dcur  = dim(mon_q, leap(year_q));
`ifdef DATE_SET_AUTOREPEAT_EN
  logic [15:0] rpt_cnt;
  logic        rpt_on, rpt_act, rpt_hit;
  assign rpt_act = edit && edit_q && (u.NUM_HOLD[0] ^ u.NUM_HOLD[1]) && !(mv_r || mv_l);
  assign rpt_hit = rpt_act && u.TICK && (rpt_cnt + 16'd1 == (rpt_on ? 16'(RPT_RATE) : 16'(RPT_DELAY)));
  assign rpt_up  = rpt_hit && u.NUM_HOLD[0];
  assign rpt_dn  = rpt_hit && u.NUM_HOLD[1];
  always_ff @(posedge CLK)
    if (RESET || !rpt_act) begin
      rpt_cnt <= '0;
      rpt_on  <= 1'b0;
    end else if (u.TICK) begin
      rpt_cnt <= rpt_hit ? '0 : rpt_cnt + 16'd1;
      rpt_on  <= rpt_on || rpt_hit;
    end
`else
  logic unused_rpt;
  assign unused_rpt = ^{u.NUM_HOLD, u.TICK};
  assign rpt_up = 1'b0;
  assign rpt_dn = 1'b0;
`endif
  always_comb begin
    cur_n    = cur_q;
    year_n   = year_q;
    mon_n    = mon_q;
    day_n    = day_q;
    dirty_n  = dirty_q;
    commit_n = 1'b0;
    if (entry) begin
      cur_n   = 3'd0;
      dirty_n = 1'b0;
      if (u.LOAD) {year_n, mon_n, day_n} = {u.LD_YEAR, u.LD_MONTH, u.LD_DAY};
    end else if (leave) begin
      commit_n = dirty_q;
      dirty_n  = 1'b0;
    end else if (!edit) begin
      if (u.LOAD) {year_n, mon_n, day_n} = {u.LD_YEAR, u.LD_MONTH, u.LD_DAY};
    end else begin
      if (step) begin
        dirty_n = 1'b1;
        if (cur_q == 3'd0)
          day_n = st_up ? (day_q >= dcur ? 5'd1 : day_q + 5'd1) : (day_q <= 5'd1 ? dcur : day_q - 5'd1);
        else if (cur_q == 3'd1)
          mon_n = st_up ? (mon_q >= 4'd12 ? 4'd1 : mon_q + 4'd1) : (mon_q <= 4'd1 ? 4'd12 : mon_q - 4'd1);
        else
          for (int i = 0; i < YEAR_DIGITS; i++)
            if (cur_q == 3'(i+2))
              year_n[4*i+:4] = st_up ? (year_q[4*i+:4] >= 4'd9 ? 4'd0 : year_q[4*i+:4] + 4'd1)
                                     : (year_q[4*i+:4] == 4'd0 ? 4'd9 : year_q[4*i+:4] - 4'd1);
        if (cur_q != 3'd0 && day_q > dim(mon_n, leap(year_n))) day_n = dim(mon_n, leap(year_n));
      end
      cur_n = mv_r ? (cur_q >= CMAX ? 3'd0 : cur_q + 3'd1) : mv_l ? (cur_q == 3'd0 ? CMAX : cur_q - 3'd1) : cur_q;
    end
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      edit_q   <= 1'b0;
      cur_q    <= 3'd0;
      year_q   <= RST_YEAR[YW-1:0];
      mon_q    <= 4'd1;
      day_q    <= 5'd1;
      dirty_q  <= 1'b0;
      commit_q <= 1'b0;
    end else begin
      edit_q   <= edit;
      cur_q    <= cur_n;
      year_q   <= year_n;
      mon_q    <= mon_n;
      day_q    <= day_n;
      dirty_q  <= dirty_n;
      commit_q <= commit_n;
    end
  assign u.CURSOR = cur_q;
  assign u.YEAR   = year_q;
  assign u.MONTH  = mon_q;
  assign u.DAY    = day_q;
  assign u.DIRTY  = dirty_q;
  assign u.COMMIT = commit_q;
endmodule

// File: tb/tb_date_set_ctrl.sv
// tb_date_set_ctrl: directed vectors for date_set_ctrl with hand-computed expectations
module tb_date_set_ctrl;
  logic CLK = 1'b0;
  logic RESET;
  int tests = 0;
  int fails = 0;
  date_set_ctrl_if #(.YEAR_DIGITS(4)) u ();
  date_set_ctrl #(.YEAR_DIGITS(4), .RPT_DELAY(3), .RPT_RATE(2)) dut (.CLK(CLK), .RESET(RESET), .u(u.slave));
  always #5 CLK = ~CLK;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask
  task automatic pulse(input logic [3:0] v);
    u.NUM_SYNC = v;
    cyc();
    u.NUM_SYNC = 4'd0;
  endtask
  task automatic load(input logic [15:0] y, input logic [3:0] m, input logic [4:0] d);
    u.LOAD = 1'b1;
    u.LD_YEAR = y;
    u.LD_MONTH = m;
    u.LD_DAY = d;
    cyc();
    u.LOAD = 1'b0;
  endtask
  initial begin
    RESET = 1'b1;
    u.NUM_SYNC = 4'd0;
    u.NUM_HOLD = 2'd0;
    u.TICK = 1'b0;
    u.MODE = 4'hF;
    u.LOAD = 1'b0;
    u.LD_YEAR = 16'h0;
    u.LD_MONTH = 4'd0;
    u.LD_DAY = 5'd0;
    cyc();
    chk("rst_year", u.YEAR, 16'h2020);
    chk("rst_month", u.MONTH, 1);
    chk("rst_day", u.DAY, 1);
    chk("rst_cursor", u.CURSOR, 0);
    chk("rst_dirty", u.DIRTY, 0);
    chk("rst_commit", u.COMMIT, 0);
    RESET = 1'b0;
    u.MODE = 4'h0;
    cyc();
    chk("entry_year", u.YEAR, 16'h2020);
    chk("entry_cursor", u.CURSOR, 0);
    chk("entry_dirty", u.DIRTY, 0);
    u.MODE = 4'hF;
    cyc();
    chk("clean_exit_commit", u.COMMIT, 0);
    cyc();
    chk("clean_exit_commit2", u.COMMIT, 0);
    u.MODE = 4'h0;
    cyc();
    u.NUM_HOLD = 2'b01;
    for (int i = 0; i < 7; i++) begin
      u.TICK = 1'b1;
      cyc();
      u.TICK = 1'b0;
      cyc();
    end
    u.NUM_HOLD = 2'b00;
`ifdef DATE_SET_AUTOREPEAT_EN
    chk("repeat_day", u.DAY, 4);
`else
    chk("hold_ignored_day", u.DAY, 1);
`endif
    pulse(4'b0100);
    pulse(4'b0010);
    chk("month_wrap_down", u.MONTH, 12);
    pulse(4'b0100);
    pulse(4'b0010);
    chk("digit_wrap_no_borrow", u.YEAR, 16'h2029);
    pulse(4'b0001);
    chk("digit_wrap_up", u.YEAR, 16'h2020);
    u.MODE = 4'hF;
    cyc();
    chk("exit_commit", u.COMMIT, 1);
    chk("exit_dirty", u.DIRTY, 0);
    cyc();
    chk("commit_one_cycle", u.COMMIT, 0);
    load(16'h2023, 4'd1, 5'd31);
    chk("load_year", u.YEAR, 16'h2023);
    chk("load_month", u.MONTH, 1);
    chk("load_day", u.DAY, 31);
    u.MODE = 4'h0;
    cyc();
    pulse(4'b0100);
    chk("cursor_month", u.CURSOR, 1);
    pulse(4'b0001);
    chk("jan31_up_month", u.MONTH, 2);
    chk("jan31_up_clamp", u.DAY, 28);
    chk("step_dirty", u.DIRTY, 1);
    u.MODE = 4'hF;
    cyc();
    cyc();
    load(16'h2000, 4'd2, 5'd29);
    u.MODE = 4'h0;
    cyc();
    pulse(4'b0100);
    pulse(4'b0010);
    chk("y2000_month_down", u.MONTH, 1);
    chk("y2000_day_kept", u.DAY, 29);
    pulse(4'b0001);
    chk("y2000_leap_day", u.DAY, 29);
    pulse(4'b0100);
    pulse(4'b0100);
    pulse(4'b0100);
    chk("cursor_hundreds", u.CURSOR, 4);
    pulse(4'b0001);
    chk("y2100_year", u.YEAR, 16'h2100);
    chk("y2100_clamp", u.DAY, 28);
    u.MODE = 4'hF;
    cyc();
    cyc();
    load(16'h2024, 4'd2, 5'd29);
    u.MODE = 4'h0;
    cyc();
    pulse(4'b0001);
    chk("feb29_up_wrap", u.DAY, 1);
    pulse(4'b0010);
    chk("feb_down_wrap", u.DAY, 29);
    pulse(4'b1000);
    chk("cursor_left_wrap", u.CURSOR, 5);
    pulse(4'b0100);
    chk("cursor_right_wrap", u.CURSOR, 0);
    pulse(4'b1100);
    chk("cursor_both", u.CURSOR, 0);
    pulse(4'b0011);
    chk("updown_ignored", u.DAY, 29);
    pulse(4'b0101);
    chk("step_old_cursor_day", u.DAY, 1);
    chk("step_and_move_cursor", u.CURSOR, 1);
    u.MODE = 4'hF;
    cyc();
    chk("exit2_commit", u.COMMIT, 1);
    chk("exit2_dirty", u.DIRTY, 0);
    cyc();
    chk("exit2_commit_drop", u.COMMIT, 0);
    u.MODE = 4'h0;
    cyc();
    pulse(4'b0001);
    chk("pre_reset_dirty", u.DIRTY, 1);
    RESET = 1'b1;
    cyc();
    RESET = 1'b0;
    chk("midedit_rst_year", u.YEAR, 16'h2020);
    chk("midedit_rst_day", u.DAY, 1);
    chk("midedit_rst_dirty", u.DIRTY, 0);
    chk("midedit_rst_commit", u.COMMIT, 0);
    cyc();
    chk("reentry_commit", u.COMMIT, 0);
    u.MODE = 4'hF;
    cyc();
    chk("post_reset_exit_commit", u.COMMIT, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
